// File: rtl/joy_db15_cond_if.sv
// Pad-conditioner boundary: raw DB15 vectors and autofire enables in, conditioned vectors and pulses out.
// Combinational bundle only; no handshake, every output is valid every clock.
interface joy_db15_cond_if;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  af_en;
  logic [15:0] joy1_out;
  logic [15:0] joy2_out;
  logic [15:0] joy1_rise;
  logic [15:0] joy2_rise;
  logic        osd_pulse;

  modport master (
    output joystick1, joystick2, af_en,
    input  joy1_out, joy2_out, joy1_rise, joy2_rise, osd_pulse
  );

  modport slave (
    input  joystick1, joystick2, af_en,
    output joy1_out, joy2_out, joy1_rise, joy2_rise, osd_pulse
  );
endinterface

// File: rtl/joy_db15_cond.sv
// Synchronise, debounce, autofire-gate and edge-detect two DB15 pad vectors; OSD combo pulse from P1.
// Latency: 2 clk sync + DEB_TICKS ticks to stable, +1 clk registered outputs; no backpressure.
module joy_db15_cond #(
  parameter int          TICK_DIV   = 48000,
  parameter int          DEB_TICKS  = 5,
  parameter int          AF_TICKS   = 33,
  parameter logic [15:0] AF_MASK    = 16'h0030,
  parameter int          HOLD_TICKS = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  joy_db15_cond_if.slave   io
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int AW = $clog2(AF_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [AW-1:0] AF_LAST   = AW'(AF_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, FIRED} osd_state_t;

  logic [31:0]   raw_m, raw_s;
  logic [31:0]   stable, stable_d;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [AW-1:0] af_cnt;
  logic          phase;
  logic [15:0]   joy1_q, joy2_q, rise1_q, rise2_q;
  logic          osd_q;

  osd_state_t    state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          fire;
  logic          combo;

  // P1 occupies [15:0], P2 [31:16] throughout the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_m <= '0;
      raw_s <= '0;
    end else begin
      raw_m <= {io.joystick2, io.joystick1};
      raw_s <= raw_m;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_deb
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt   <= '0;
        stable[i] <= 1'b0;
      end else if (tick) begin
        if (raw_s[i] == stable[i]) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          stable[i] <= raw_s[i];
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  // Phase starts high so reset comes up passing buttons through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_cnt <= '0;
      phase  <= 1'b1;
    end else if (tick) begin
      if (af_cnt == AF_LAST) begin
        af_cnt <= '0;
        phase  <= ~phase;
      end else begin
        af_cnt <= af_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
      joy1_q   <= '0;
      joy2_q   <= '0;
      rise1_q  <= '0;
      rise2_q  <= '0;
      osd_q    <= 1'b0;
    end else begin
      stable_d <= stable;
      joy1_q   <= stable[15:0]  & ~(AF_MASK & {16{io.af_en[0] & ~phase}});
      joy2_q   <= stable[31:16] & ~(AF_MASK & {16{io.af_en[1] & ~phase}});
      rise1_q  <= stable[15:0]  & ~stable_d[15:0];
      rise2_q  <= stable[31:16] & ~stable_d[31:16];
      osd_q    <= fire;
    end
  end

  assign combo = stable[11] & stable[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  // Release is checked before expiry, so a drop on the expiring tick cancels the pulse
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (combo) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
        end
      end
      HOLD: begin
        if (!combo) begin
          state_n = IDLE;
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            fire    = 1'b1;
            state_n = FIRED;
          end else begin
            hold_cnt_n = hold_cnt + 1'b1;
          end
        end
      end
      FIRED: begin
        if (!combo) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign io.joy1_out  = joy1_q;
  assign io.joy2_out  = joy2_q;
  assign io.joy1_rise = rise1_q;
  assign io.joy2_rise = rise2_q;
  assign io.osd_pulse = osd_q;

endmodule

// File: tb/tb_joy_db15_cond.sv
// Directed bench for joy_db15_cond: steady-state vector table plus multi-cycle sequences.
module tb_joy_db15_cond;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  joy_db15_cond_if jif ();

  joy_db15_cond #(
    .TICK_DIV   (4),
    .DEB_TICKS  (3),
    .AF_TICKS   (2),
    .AF_MASK    (16'h0030),
    .HOLD_TICKS (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (jif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic [1:0]  af;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [15:0] j1, input logic [15:0] j2, input logic [1:0] af);
    jif.joystick1 = j1;
    jif.joystick2 = j2;
    jif.af_en     = af;
  endtask

  logic [31:0] all_out;
  assign all_out = {jif.joy1_out, jif.joy2_out} | {jif.joy1_rise, jif.joy2_rise}
                 | {31'd0, jif.osd_pulse};

  initial begin
    vec_t vt[6];
    int cnt, cnt2, t1, t2, last, trans, first_hit;
    logic prev;

    drive(16'h0, 16'h0, 2'b00);
    #23;
    check("reset_outputs", all_out, 32'h0);
    rst_n = 1'b1;
    step(4);

    vt[0] = '{16'h0001, 16'h0000, 2'b00, 16'h0001, 16'h0000};
    vt[1] = '{16'h0000, 16'h8000, 2'b00, 16'h0000, 16'h8000};
    vt[2] = '{16'h0FFF, 16'hF000, 2'b00, 16'h0FFF, 16'hF000};
    vt[3] = '{16'h0F0F, 16'h00C0, 2'b11, 16'h0F0F, 16'h00C0};
    vt[4] = '{16'hA5A5, 16'h5A5A, 2'b00, 16'hA5A5, 16'h5A5A};
    vt[5] = '{16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000};
    for (int v = 0; v < 6; v++) begin
      drive(vt[v].j1, vt[v].j2, vt[v].af);
      step(24);
      check($sformatf("vec%0d_joy1", v), {16'h0, jif.joy1_out}, {16'h0, vt[v].exp1});
      check($sformatf("vec%0d_joy2", v), {16'h0, jif.joy2_out}, {16'h0, vt[v].exp2});
    end
    step(10);

    // single press: output within bound, exactly one rise clock
    drive(16'h0001, 16'h0, 2'b00);
    cnt = 0; first_hit = -1;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (jif.joy1_rise[0]) cnt++;
      if (first_hit < 0 && jif.joy1_out[0]) first_hit = k + 1;
    end
    check("press_latency_ok", {31'd0, (first_hit > 0 && first_hit <= 19)}, 32'd1);
    check("press_rise_count", cnt, 1);
    drive(16'h0, 16'h0, 2'b00);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (jif.joy1_rise != 16'h0) cnt++;
    end
    check("release_no_rise", cnt, 0);
    check("release_out", {16'h0, jif.joy1_out}, 32'h0);

    // glitch of two ticks never reaches the output
    drive(16'h0001, 16'h0, 2'b00);
    step(8);
    drive(16'h0, 16'h0, 2'b00);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (jif.joy1_out[0] || jif.joy1_rise[0]) cnt++;
    end
    check("glitch_filtered", cnt, 0);

    // autofire on P2 button A: toggle every 8 clk, then steady when disabled
    drive(16'h0, 16'h0010, 2'b10);
    step(24);
    prev = jif.joy2_out[4]; last = -1; trans = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (jif.joy2_out[4] != prev) begin
        if (last >= 0) check("af_half_period", k - last, 8);
        last = k; trans++;
        prev = jif.joy2_out[4];
      end
    end
    check("af_toggles_seen", {31'd0, trans >= 4}, 32'd1);
    drive(16'h0, 16'h0010, 2'b00);
    step(1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (!jif.joy2_out[4]) cnt++;
    end
    check("af_off_steady", cnt, 0);
    drive(16'h0, 16'h0, 2'b00);
    step(24);

    // OSD combo: one pulse per hold, re-arms after release
    drive(16'h0C00, 16'h0, 2'b00);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (jif.osd_pulse) cnt++;
    end
    check("osd_one_pulse", cnt, 1);
    check("osd_combo_passes", {16'h0, jif.joy1_out}, 32'h0C00);
    drive(16'h0, 16'h0, 2'b00);
    step(30);
    drive(16'h0C00, 16'h0, 2'b00);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step(1);
      if (jif.osd_pulse) cnt++;
    end
    check("osd_second_pulse", cnt, 1);

    // reset mid-hold with inputs high
    drive(16'h0C00, 16'h0101, 2'b00);
    step(20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", all_out, 32'h0);
    step(3);
    check("reset_held_clear", all_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (all_out != 32'h0) cnt++;
    end
    check("reset_release_quiet", cnt, 0);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step(1);
      if (jif.joy1_rise[10]) cnt++;
      if (jif.osd_pulse) cnt2++;
    end
    check("reset_rise_once", cnt, 1);
    check("reset_outs_back", {jif.joy1_out, jif.joy2_out}, 32'h0C00_0101);
    check("reset_osd_rearmed", cnt2, 1);
    drive(16'h0, 16'h0, 2'b00);
    step(30);

    // simultaneous independent players
    drive(16'h0001, 16'h8000, 2'b00);
    t1 = -1; t2 = -1;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (jif.joy1_rise[0])  t1 = k;
      if (jif.joy2_rise[15]) t2 = k;
    end
    check("simul_rise_seen", {31'd0, t1 >= 0}, 32'd1);
    check("simul_same_clk", t1, t2);
    check("simul_outs", {jif.joy1_out, jif.joy2_out}, 32'h0001_8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
